// File: rtl/cx_pkg.sv
// Shared types and constants for the CX request arbiter.
package cx_pkg;

  localparam int unsigned CX_ID_W     = 2;
  localparam int unsigned CX_DATA_W   = 32;
  localparam int unsigned CX_STATUS_W = 4;

  localparam logic [CX_STATUS_W-1:0] CX_STATUS_BAD_CXU = 4'hE;
  localparam logic [CX_STATUS_W-1:0] CX_STATUS_TIMEOUT = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    DELIVER,
    ERR_RESP,
    DRAIN
  } arb_state_e;

endpackage

// File: rtl/cx_req_arbiter_if.sv
// Requester-side and switch-side CX signals; slave is the arbiter's view,
// master the view of the requesters and switch around it.
interface cx_req_arbiter_if #(
  parameter int unsigned N_REQ = 2
) ();
  import cx_pkg::*;

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_ready;
  logic [CX_ID_W*N_REQ-1:0]     req_cxu_id;
  logic [CX_ID_W*N_REQ-1:0]     req_state_id;
  logic [CX_DATA_W*N_REQ-1:0]   req_data0;
  logic [CX_DATA_W*N_REQ-1:0]   req_data1;
  logic [N_REQ-1:0]             resp_valid;
  logic [N_REQ-1:0]             resp_ready;
  logic [CX_STATUS_W-1:0]       resp_status;
  logic [CX_DATA_W-1:0]         resp_data;

  logic                         cx_req_valid;
  logic                         cx_req_ready;
  logic [CX_ID_W-1:0]           cx_cxu_id;
  logic [CX_ID_W-1:0]           cx_state_id;
  logic [CX_DATA_W-1:0]         cx_req_data0;
  logic [CX_DATA_W-1:0]         cx_req_data1;
  logic                         cx_resp_valid;
  logic                         cx_resp_ready;
  logic [CX_STATUS_W-1:0]       cx_resp_status;
  logic [CX_DATA_W-1:0]         cx_resp_data;

  modport slave (
    input  req_valid, req_cxu_id, req_state_id, req_data0, req_data1, resp_ready,
    input  cx_req_ready, cx_resp_valid, cx_resp_status, cx_resp_data,
    output req_ready, resp_valid, resp_status, resp_data,
    output cx_req_valid, cx_cxu_id, cx_state_id, cx_req_data0, cx_req_data1, cx_resp_ready
  );

  modport master (
    output req_valid, req_cxu_id, req_state_id, req_data0, req_data1, resp_ready,
    output cx_req_ready, cx_resp_valid, cx_resp_status, cx_resp_data,
    input  req_ready, resp_valid, resp_status, resp_data,
    input  cx_req_valid, cx_cxu_id, cx_state_id, cx_req_data0, cx_req_data1, cx_resp_ready
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request starting at ptr_i, wrapping.
module rr_picker #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PtrW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PtrW-1:0]  ptr_i,
  output logic             found_o,
  output logic [PtrW-1:0]  winner_o
);

  logic            found_c;
  logic [PtrW-1:0] winner_c;

  // Outer loop walks priority order; inner loop keeps every bit select constant.
  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!found_c && req_i[j] && (j == (32'(ptr_i) + i) % N_REQ)) begin
          found_c  = 1'b1;
          winner_c = PtrW'(j);
        end
      end
    end
  end

  assign found_o  = found_c;
  assign winner_o = winner_c;

endmodule

// File: rtl/cx_req_arbiter.sv
// Round-robin sharing of one CX request/response channel between N_REQ requesters,
// with local bad-ID rejection and a bounded response wait followed by a drain.
module cx_req_arbiter
  import cx_pkg::*;
#(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned N_CXU          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  cx_req_arbiter_if.slave     bus,
  output logic                busy,
  output logic                err_timeout
);

  localparam int unsigned PtrW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TimerW-1:0] TimerLast =
      TimerW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(N_REQ - 1);

  arb_state_e             state_q, state_d;
  logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]        grant_q, grant_d;
  logic [TimerW-1:0]      timer_q, timer_d;
  logic [CX_ID_W-1:0]     cxu_id_q, cxu_id_d;
  logic [CX_ID_W-1:0]     state_id_q, state_id_d;
  logic [CX_DATA_W-1:0]   data0_q, data0_d;
  logic [CX_DATA_W-1:0]   data1_q, data1_d;
  logic [CX_STATUS_W-1:0] status_q, status_d;
  logic [CX_DATA_W-1:0]   rdata_q, rdata_d;
  logic                   timed_out_q, timed_out_d;

  logic                   pick_found;
  logic [PtrW-1:0]        pick_idx;
  logic [N_REQ-1:0]       grant_oh;
  logic [N_REQ-1:0]       req_ready_c;
  logic [N_REQ-1:0]       resp_valid_c;
  logic [CX_STATUS_W-1:0] resp_status_c;
  logic [CX_DATA_W-1:0]   resp_data_c;
  logic                   cx_req_valid_c;
  logic                   cx_resp_ready_c;
  logic                   err_timeout_c;

  rr_picker #(
    .N_REQ (N_REQ),
    .PtrW  (PtrW)
  ) u_picker (
    .req_i    (bus.req_valid),
    .ptr_i    (rr_ptr_q),
    .found_o  (pick_found),
    .winner_o (pick_idx)
  );

  always_comb begin
    grant_oh = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      grant_oh[j] = (PtrW'(j) == grant_q);
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    timer_d         = timer_q;
    cxu_id_d        = cxu_id_q;
    state_id_d      = state_id_q;
    data0_d         = data0_q;
    data1_d         = data1_q;
    status_d        = status_q;
    rdata_d         = rdata_q;
    timed_out_d     = timed_out_q;
    req_ready_c     = '0;
    resp_valid_c    = '0;
    resp_status_c   = '0;
    resp_data_c     = '0;
    cx_req_valid_c  = 1'b0;
    cx_resp_ready_c = 1'b0;
    err_timeout_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          for (int unsigned j = 0; j < N_REQ; j++) begin
            if (PtrW'(j) == pick_idx) begin
              req_ready_c[j] = 1'b1;
              cxu_id_d       = bus.req_cxu_id[CX_ID_W*j +: CX_ID_W];
              state_id_d     = bus.req_state_id[CX_ID_W*j +: CX_ID_W];
              data0_d        = bus.req_data0[CX_DATA_W*j +: CX_DATA_W];
              data1_d        = bus.req_data1[CX_DATA_W*j +: CX_DATA_W];
            end
          end
          grant_d     = pick_idx;
          rr_ptr_d    = (pick_idx == PtrLast) ? '0 : pick_idx + 1'b1;
          timed_out_d = 1'b0;
          if (32'(cxu_id_d) >= N_CXU) begin
            state_d  = ERR_RESP;
            status_d = CX_STATUS_BAD_CXU;
            rdata_d  = '0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cx_req_valid_c = 1'b1;
        if (bus.cx_req_ready) begin
          state_d = WAIT_RESP;
          timer_d = '0;
        end
      end
      WAIT_RESP: begin
        cx_resp_ready_c = 1'b1;
        if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
        // A response in the expiry cycle takes precedence over the timeout.
        if (bus.cx_resp_valid) begin
          state_d  = DELIVER;
          status_d = bus.cx_resp_status;
          rdata_d  = bus.cx_resp_data;
        end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TimerLast)) begin
          state_d       = ERR_RESP;
          status_d      = CX_STATUS_TIMEOUT;
          rdata_d       = '0;
          timed_out_d   = 1'b1;
          err_timeout_c = 1'b1;
        end
      end
      DELIVER, ERR_RESP: begin
        resp_valid_c  = grant_oh;
        resp_status_c = status_q;
        resp_data_c   = rdata_q;
        if (|(bus.resp_ready & grant_oh)) begin
          state_d = (state_q == ERR_RESP && timed_out_q) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        cx_resp_ready_c = 1'b1;
        if (bus.cx_resp_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      timer_q     <= '0;
      cxu_id_q    <= '0;
      state_id_q  <= '0;
      data0_q     <= '0;
      data1_q     <= '0;
      status_q    <= '0;
      rdata_q     <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      timer_q     <= timer_d;
      cxu_id_q    <= cxu_id_d;
      state_id_q  <= state_id_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign bus.req_ready     = req_ready_c;
  assign bus.resp_valid    = resp_valid_c;
  assign bus.resp_status   = resp_status_c;
  assign bus.resp_data     = resp_data_c;
  assign bus.cx_req_valid  = cx_req_valid_c;
  assign bus.cx_cxu_id     = cxu_id_q;
  assign bus.cx_state_id   = state_id_q;
  assign bus.cx_req_data0  = data0_q;
  assign bus.cx_req_data1  = data1_q;
  assign bus.cx_resp_ready = cx_resp_ready_c;
  assign busy              = (state_q != IDLE);
  assign err_timeout       = err_timeout_c;

endmodule

// File: doc/cx_req_arbiter.md
Name: cx_req_arbiter

Overview:
- Shares the single CX request/response channel into the CXU switch between N_REQ requesters (e.g. Ibex core port, debug/test port).
- Round-robin arbitration; one transaction outstanding at a time; the grant is held from request accept until the requester accepts the response.
- Rejects out-of-range CXU IDs locally.
- Bounds the response wait with a timeout, then drains the late downstream response.

Parameters:
N_REQ, 2, number of requester ports (2..4)
N_CXU, 4, number of CXUs behind the switch (1..4); cxu_id >= N_CXU is illegal
TIMEOUT_CYCLES, 255, max cycles in WAIT_RESP before error; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester request accept
req_cxu_id  in  2*N_REQ  packed CXU IDs (requester i at [2i+1:2i])
req_state_id  in  2*N_REQ  packed state IDs
req_data0  in  32*N_REQ  packed operand 0
req_data1  in  32*N_REQ  packed operand 1
resp_valid  out  N_REQ  per-requester response valid
resp_ready  in  N_REQ  per-requester response accept
resp_status  out  4  status of the response (shared, qualified by resp_valid)
resp_data  out  32  response data (shared, qualified by resp_valid)
cx_req_valid  out  1  request to switch
cx_req_ready  in  1  switch accepts request
cx_cxu_id  out  2  registered CXU ID
cx_state_id  out  2  registered state ID
cx_req_data0  out  32  registered operand 0
cx_req_data1  out  32  registered operand 1
cx_resp_valid  in  1  switch response valid
cx_resp_ready  out  1  arbiter accepts response
cx_resp_status  in  4  switch response status
cx_resp_data  in  32  switch response data
busy  out  1  state != IDLE
err_timeout  out  1  one-cycle pulse on timeout

Behaviour:
Reset values:
- state=IDLE, rr_ptr=0, grant=0, timer=0.
- All payload registers zero.
- All valids/readys low, except req_ready as defined for IDLE.
- err_timeout=0.

Reset mid-operation: immediate return to IDLE; the in-flight transaction is lost, with no response.

IDLE:
- Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, … modulo N_REQ.
- req_ready[winner]=1 combinationally, same cycle; all other req_ready bits are 0.
- On handshake: latch the winner's cxu_id/state_id/data0/data1, set grant=winner, set rr_ptr=(winner+1) mod N_REQ.
- If latched cxu_id >= N_CXU, go to ERR_RESP with status 4'hE; otherwise go to ISSUE.

ISSUE:
- cx_req_valid=1, payload from registers.
- On cx_req_ready: go to WAIT_RESP, timer=0.
- No timeout in this state.

WAIT_RESP:
- cx_resp_ready=1; timer increments each cycle.
- On cx_resp_valid: latch status/data, go to DELIVER.
- Else if TIMEOUT_CYCLES != 0 and timer == TIMEOUT_CYCLES-1: go to ERR_RESP with status 4'hF, data 0, err_timeout pulse.
- If cx_resp_valid and timeout occur in the same cycle, the response wins and there is no error.

DELIVER:
- resp_valid[grant]=1, resp_status/resp_data from latches.
- On resp_ready[grant]: go to IDLE.

ERR_RESP:
- Same handshake as DELIVER, using the error status and data=0.
- On resp_ready[grant]: go to DRAIN if entered by timeout, else to IDLE.

DRAIN:
- cx_resp_ready=1; on cx_resp_valid, discard and go to IDLE.
- No timeout; busy stays high.

General rules:
- Invariants: resp_status/resp_data hold 0 when no resp_valid; at most one resp_valid bit set.
- req_ready is 0 in every state except IDLE.
- New arbitration happens only in IDLE, i.e. one cycle after the previous response handshake.
- Timer width is $clog2(TIMEOUT_CYCLES+1), minimum 1; it saturates and never wraps.

Decomposition:
- Package cx_pkg holds: arb_state_e enum (IDLE, ISSUE, WAIT_RESP, DELIVER, ERR_RESP, DRAIN); CX_STATUS_BAD_CXU=4'hE; CX_STATUS_TIMEOUT=4'hF; CX_ID_W=2; CX_DATA_W=32; CX_STATUS_W=4.
- Sub-module rr_picker (N_REQ): combinational; inputs req vector and rr_ptr; outputs found and winner index.

Test Plan:
1. Single request: req0 valid, cxu_id=1, data0=0x11, data1=0x22; switch ready after 2 cycles, responds with status 0, data 0xABCD after 3 cycles -> cx_* payload matches; resp_valid[0] with data 0xABCD; busy drops after resp_ready.
2. Contention: req0 and req1 held valid continuously for 4 transactions -> grant order 0,1,0,1; the losing req_ready stays 0; rr_ptr wraps from 1 to 0.
3. Illegal ID with N_CXU=2: req1 cxu_id=3 -> cx_req_valid never asserted; resp_valid[1] next cycle with status 4'hE, data 0; returns to IDLE.
4. Timeout with TIMEOUT_CYCLES=8 and no response -> err_timeout pulses in the 8th WAIT_RESP cycle; status 4'hF delivered; late cx_resp_valid is drained and never reaches any requester.
5. Tie: cx_resp_valid arrives exactly in the 8th WAIT_RESP cycle -> normal DELIVER, no err_timeout.
6. Reset asserted during WAIT_RESP -> all outputs at reset values immediately (asynchronously); after deassert, a new req0 is granted normally.
